branch_target_buffer: RTL
=========================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter PC_BITS, 32, PC width in bits; byte address, word-aligned.
REQ-002 Parameter DEPTH, 16, number of fully-associative entries; power of two, minimum 2.
REQ-003 Parameter INDX, 4, log2(DEPTH).
REQ-004 Reset rst, synchronous, active-high; clock clk.
REQ-005 Port list, in order:
- clk  in  1  clock
- rst  in  1  reset
- F_pc_va  in  PC_BITS  fetch PC
- F_stall, MEM_stall, Itlb_stall  in  1 each  pipeline stalls
- flush  in  1  invalidate the whole table
- EX_brn  in  1  qualified branch in EX
- EX_pc  in  PC_BITS  PC of the EX branch
- EX_alu_out  in  PC_BITS  resolved target
- EX_true_taken  in  1  resolved direction
- EX_pred_taken  in  1  prediction carried down the pipe
- EX_pred_target  in  PC_BITS  predicted target carried down the pipe
- F_BP_target_pc  out  PC_BITS  predicted next PC
- F_BP_taken  out  1  predicted taken
- F_BP_hit  out  1  fetch PC hit a valid entry
- EX_mispredict  out  1  EX branch was mispredicted

Function
REQ-006 Each entry SHALL hold: valid bit, tag = PC[PC_BITS-1:2], target, and a 2-bit saturating counter.
REQ-007 Fetch lookup SHALL be combinational. A hit is a valid entry whose tag equals F_pc_va[PC_BITS-1:2]. The lowest matching index wins.
REQ-008 F_BP_taken SHALL equal hit AND counter[1].
REQ-009 F_BP_target_pc SHALL be the stored target when F_BP_taken=1; otherwise seq_pc.
REQ-010 seq_pc SHALL be F_pc_va+4 when none of F_stall, MEM_stall or Itlb_stall is set; otherwise F_pc_va. Addition wraps modulo 2^PC_BITS.
REQ-011 EX_mispredict SHALL be EX_brn AND (EX_pred_taken != EX_true_taken OR (EX_true_taken AND EX_pred_target != EX_alu_out)). It is combinational.
REQ-012 On EX_brn with an EX tag hit, the entry's counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0. The target SHALL be overwritten with EX_alu_out only when taken.
REQ-013 On EX_brn with an EX tag miss, a new entry SHALL be allocated: valid=1, tag, target=EX_alu_out, counter=2 if taken else 1.
REQ-014 Allocation victim selection:
- the lowest-index invalid entry, if any exists;
- otherwise the entry at the round-robin pointer vptr, after which vptr increments, wrapping DEPTH-1 -> 0;
- vptr SHALL NOT move when an invalid entry is used.
REQ-015 An update in cycle N SHALL become visible to fetch lookup in cycle N+1. There is no same-cycle bypass.
REQ-016 flush SHALL clear all valid bits and counters and set vptr=0 at the next edge. flush has priority over a simultaneous EX_brn, which is dropped.
REQ-017 Table updates SHALL NOT be gated by any stall input.

Reset
REQ-018 Reset SHALL clear all valid bits, counters, targets, tags and vptr. A reset asserted mid-update SHALL override the update.
REQ-019 After reset, outputs SHALL be: F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=seq_pc, EX_mispredict per REQ-011.

Configuration
REQ-020 Macro BTB_STATS_EN. When defined, three 32-bit saturating output counters SHALL be added:
- stat_lookups: increments each cycle with no stall asserted;
- stat_hits: increments when additionally F_BP_hit=1;
- stat_mispredicts: increments on EX_mispredict.
REQ-021 The statistics counters SHALL be cleared by rst and by flush. When BTB_STATS_EN is undefined, the ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-022 Package bp_pkg SHALL hold the counter constants SNT=0, WNT=1, WT=2, ST=3, CTR_BITS=2 and STAT_BITS=32.
REQ-023 Sub-module btb_cam_match (valid vector plus tag array plus key -> hit, idx, lowest index first) SHALL be instantiated twice: once for fetch and once for EX.

Verification
REQ-024 Reset, then F_pc_va=0x100 with no stall -> F_BP_hit=0, F_BP_taken=0, F_BP_target_pc=0x104. With F_stall=1 -> target 0x100.
REQ-025 EX_brn, EX_pc=0x100, EX_alu_out=0x200, taken -> next cycle F_pc_va=0x100 gives hit=1, taken=1, target=0x200. Two not-taken updates follow -> counter=0, taken=0, target=0x104.
REQ-026 Four taken updates of 0x100 -> counter stays 3. One not-taken -> still predicts taken.
REQ-027 Insert DEPTH+2 distinct branches -> entries 0 and 1 are replaced in that order, and vptr=2.
REQ-028 flush together with EX_brn in the same cycle -> every lookup misses next cycle, and there is no new entry.
REQ-029 EX_pred_taken=1, EX_pred_target=0x300, true taken with EX_alu_out=0x200 -> EX_mispredict=1. With BTB_STATS_EN defined, stat_mispredicts increments by 1.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor constants, counter type and saturating counter step.
package bp_pkg;
    localparam int CTR_BITS  = 2;
    localparam int STAT_BITS = 32;
    typedef logic [CTR_BITS-1:0] ctr_t;
    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;
    function automatic ctr_t sat_ctr(ctr_t c, logic up);
        return up ? ((c == ST) ? ST : c + 1'b1) : ((c == SNT) ? SNT : c - 1'b1);
    endfunction
endpackage

// File: rtl/btb_cam_match.sv
// btb_cam_match: fully-associative tag match over a valid vector; lowest matching index wins.
module btb_cam_match #(
    parameter int DEPTH    = 16,
    parameter int INDX     = 4,
    parameter int TAG_BITS = 30
) (
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0][TAG_BITS-1:0] tags,
    input  logic [TAG_BITS-1:0]            key,
    output logic                           hit,
    output logic [INDX-1:0]                idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == key) begin
                hit = 1'b1;
                idx = INDX'(i);
            end
        end
    end
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: fully-associative BTB with 2-bit counters and round-robin replacement.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 16,
    parameter int INDX    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_BITS-1:0] F_pc_va,
    input  logic               F_stall,
    input  logic               MEM_stall,
    input  logic               Itlb_stall,
    input  logic               flush,
    input  logic               EX_brn,
    input  logic [PC_BITS-1:0] EX_pc,
    input  logic [PC_BITS-1:0] EX_alu_out,
    input  logic               EX_true_taken,
    input  logic               EX_pred_taken,
    input  logic [PC_BITS-1:0] EX_pred_target,
    output logic [PC_BITS-1:0] F_BP_target_pc,
    output logic               F_BP_taken,
    output logic               F_BP_hit,
    output logic               EX_mispredict
`ifdef BTB_STATS_EN
    ,
    output logic [STAT_BITS-1:0] stat_lookups,
    output logic [STAT_BITS-1:0] stat_hits,
    output logic [STAT_BITS-1:0] stat_mispredicts
`endif
);
    localparam int TAG_BITS = PC_BITS - 2;

    logic [DEPTH-1:0]               valid_q, valid_d;
    logic [DEPTH-1:0][TAG_BITS-1:0] tag_q, tag_d;
    logic [DEPTH-1:0][PC_BITS-1:0]  target_q, target_d;
    ctr_t [DEPTH-1:0]               ctr_q, ctr_d;
    logic [INDX-1:0]                vptr_q, vptr_d;

    logic            f_hit, ex_hit, inv_any, any_stall;
    logic [INDX-1:0] f_idx, ex_idx, inv_idx, alloc_idx;
    logic [PC_BITS-1:0] seq_pc;
    logic unused_pc_bits;

    assign unused_pc_bits = ^{F_pc_va[1:0], EX_pc[1:0]};

    btb_cam_match #(.DEPTH(DEPTH), .INDX(INDX), .TAG_BITS(TAG_BITS)) u_fetch_match (
        .valid(valid_q), .tags(tag_q), .key(F_pc_va[PC_BITS-1:2]), .hit(f_hit), .idx(f_idx)
    );

    btb_cam_match #(.DEPTH(DEPTH), .INDX(INDX), .TAG_BITS(TAG_BITS)) u_ex_match (
        .valid(valid_q), .tags(tag_q), .key(EX_pc[PC_BITS-1:2]), .hit(ex_hit), .idx(ex_idx)
    );

    always_comb begin
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_any = 1'b1;
                inv_idx = INDX'(i);
            end
        end
    end

    assign alloc_idx      = inv_any ? inv_idx : vptr_q;
    assign any_stall      = F_stall | MEM_stall | Itlb_stall;
    assign seq_pc         = any_stall ? F_pc_va : F_pc_va + PC_BITS'(4);
    assign F_BP_hit       = f_hit;
    assign F_BP_taken     = f_hit & ctr_q[f_idx][1];
    assign F_BP_target_pc = F_BP_taken ? target_q[f_idx] : seq_pc;
    assign EX_mispredict  = EX_brn & ((EX_pred_taken != EX_true_taken) |
                                      (EX_true_taken & (EX_pred_target != EX_alu_out)));

    // Flush drops a coincident EX update; stalls never gate training.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        vptr_d   = vptr_q;
        if (flush) begin
            valid_d = '0;
            ctr_d   = '0;
            vptr_d  = '0;
        end else if (EX_brn && ex_hit) begin
            ctr_d[ex_idx] = sat_ctr(ctr_q[ex_idx], EX_true_taken);
            if (EX_true_taken) target_d[ex_idx] = EX_alu_out;
        end else if (EX_brn) begin
            valid_d[alloc_idx]  = 1'b1;
            tag_d[alloc_idx]    = EX_pc[PC_BITS-1:2];
            target_d[alloc_idx] = EX_alu_out;
            ctr_d[alloc_idx]    = EX_true_taken ? WT : WNT;
            vptr_d              = inv_any ? vptr_q : vptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= '0;
            vptr_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            vptr_q   <= vptr_d;
        end
    end

`ifdef BTB_STATS_EN
    logic [STAT_BITS-1:0] lookups_q, lookups_d, hits_q, hits_d, misp_q, misp_d;

    always_comb begin
        lookups_d = flush ? '0 : (!any_stall && !(&lookups_q)) ? lookups_q + 1'b1 : lookups_q;
        hits_d    = flush ? '0 : (!any_stall && f_hit && !(&hits_q)) ? hits_q + 1'b1 : hits_q;
        misp_d    = flush ? '0 : (EX_mispredict && !(&misp_q)) ? misp_q + 1'b1 : misp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
            misp_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            misp_q    <= misp_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = misp_q;
`endif
endmodule
